// File: rtl/piano_scheduler.sv
// piano_scheduler: sequencing controller between the UART receive path and
// the square-wave tone generator.
//
// Received ASCII note bytes are buffered in a small queue. Each byte is looked
// up in an external note-period ROM, played for note_len cycles, and echoed
// back on UART TX when the note starts. The rotary wheel adjusts note_len in
// saturating steps. A stop pulse aborts the current note and flushes the queue.
//
// Ports:
//   clk, rst_b                  system clock, asynchronous active-low reset
//   ua_rx_data/valid/ready      byte stream from UART RX into the note queue
//   ua_tx_data/valid/ready      echo of each started note to UART TX
//   rotary_event, rotary_left   one-cycle duration step, left = shorter
//   stop                        one-cycle abort and queue flush
//   rom_addr, rom_data          note ROM lookup, data valid one cycle after addr
//   tone_period, tone_enable    tone generator controls
//   queue_count                 entries currently queued
//   busy                        sequencer is not idle
module piano_scheduler #(
    parameter int unsigned CLOCK_FREQ       = 33_000_000,
    parameter int unsigned NOTE_LEN_DEFAULT = CLOCK_FREQ / 5,
    parameter int unsigned NOTE_LEN_STEP    = CLOCK_FREQ / 50,
    parameter int unsigned NOTE_LEN_MIN     = CLOCK_FREQ / 50,
    parameter int unsigned NOTE_LEN_MAX     = CLOCK_FREQ,
    parameter int unsigned QUEUE_DEPTH      = 4,
    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [7:0]        ua_rx_data,
    input  logic              ua_rx_valid,
    output logic              ua_rx_ready,
    output logic [7:0]        ua_tx_data,
    output logic              ua_tx_valid,
    input  logic              ua_tx_ready,
    input  logic              rotary_event,
    input  logic              rotary_left,
    input  logic              stop,
    output logic [7:0]        rom_addr,
    input  logic [23:0]       rom_data,
    output logic [23:0]       tone_period,
    output logic              tone_enable,
    output logic [CNT_W-1:0]  queue_count,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        queue_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              load;
    logic              play_done;
    logic [7:0]        echo_byte;
    logic [31:0]       note_len;
    logic [31:0]       play_cnt;

    // Saturating duration step up, bounded by NOTE_LEN_MAX.
    function automatic logic [31:0] len_inc(input logic [31:0] len);
        logic [31:0] sum;
        sum = len + NOTE_LEN_STEP;
        return (sum > NOTE_LEN_MAX) ? NOTE_LEN_MAX : sum;
    endfunction

    // Saturating duration step down, bounded by NOTE_LEN_MIN. The comparison
    // is done before subtracting so the value can never wrap below zero.
    function automatic logic [31:0] len_dec(input logic [31:0] len);
        return (len < NOTE_LEN_MIN + NOTE_LEN_STEP) ? NOTE_LEN_MIN : len - NOTE_LEN_STEP;
    endfunction

    assign full        = (count == CNT_W'(QUEUE_DEPTH));
    assign empty       = (count == '0);
    // Ready ignores a same-cycle pop; it is forced low during reset and stop.
    assign ua_rx_ready = rst_b & ~full & ~stop;
    assign push        = ua_rx_valid & ua_rx_ready;
    assign queue_count = count;

    // State register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; a note waits in IDLE until the previous echo is taken.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!empty && !ua_tx_valid) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_PLAY;
            S_PLAY:  if (play_cnt == '0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (stop) state_nxt = S_IDLE;
    end

    // FSM strobes
    always_comb begin
        pop       = (state == S_IDLE) & ~empty & ~ua_tx_valid & ~stop;
        load      = (state == S_LOAD) & ~stop;
        play_done = (state == S_PLAY) & (play_cnt == '0);
        busy      = (state != S_IDLE);
    end

    // Queue storage holds data only, no reset needed.
    always_ff @(posedge clk) begin
        if (push) queue_mem[wr_ptr] <= ua_rx_data;
    end

    // Queue pointers and occupancy; pointers wrap naturally at the
    // power-of-two depth.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (stop) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Note sequencing datapath: ROM address and echo capture on pop, tone and
    // echo launch on leaving LOAD, countdown during PLAY.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rom_addr    <= '0;
            echo_byte   <= '0;
            tone_period <= '0;
            tone_enable <= 1'b0;
            ua_tx_data  <= '0;
            ua_tx_valid <= 1'b0;
            play_cnt    <= '0;
        end else begin
            if (pop) begin
                rom_addr  <= queue_mem[rd_ptr];
                echo_byte <= queue_mem[rd_ptr];
            end
            if (load) begin
                tone_period <= rom_data;
                tone_enable <= (rom_data != '0);
                play_cnt    <= note_len - 32'd1;
                ua_tx_data  <= echo_byte;
                ua_tx_valid <= 1'b1;
            end else if (ua_tx_valid && ua_tx_ready) begin
                ua_tx_valid <= 1'b0;
            end
            if (play_done) begin
                tone_enable <= 1'b0;
            end else if (state == S_PLAY) begin
                play_cnt <= play_cnt - 32'd1;
            end
            // A pending echo survives stop; only the tone is cut.
            if (stop) tone_enable <= 1'b0;
        end
    end

    // Duration is sampled at LOAD, so changes mid-note apply to later notes.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            note_len <= NOTE_LEN_DEFAULT;
        end else if (rotary_event) begin
            note_len <= rotary_left ? len_dec(note_len) : len_inc(note_len);
        end
    end

endmodule

// File: tb/tb_piano_scheduler.sv
`timescale 1ns/1ps
module tb_piano_scheduler;

    localparam int LEN_DEF = 10;
    localparam int STEP    = 2;
    localparam int LMIN    = 2;
    localparam int LMAX    = 20;
    localparam int DEPTH   = 4;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic [7:0]  ua_rx_data = '0;
    logic        ua_rx_valid = 1'b0;
    logic        ua_rx_ready;
    logic [7:0]  ua_tx_data;
    logic        ua_tx_valid;
    logic        ua_tx_ready = 1'b1;
    logic        rotary_event = 1'b0;
    logic        rotary_left = 1'b0;
    logic        stop = 1'b0;
    logic [7:0]  rom_addr;
    logic [23:0] rom_data = '0;
    logic [23:0] tone_period;
    logic        tone_enable;
    logic [2:0]  queue_count;
    logic        busy;

    piano_scheduler #(
        .CLOCK_FREQ(100), .NOTE_LEN_DEFAULT(LEN_DEF), .NOTE_LEN_STEP(STEP),
        .NOTE_LEN_MIN(LMIN), .NOTE_LEN_MAX(LMAX), .QUEUE_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_b(rst_b),
        .ua_rx_data(ua_rx_data), .ua_rx_valid(ua_rx_valid), .ua_rx_ready(ua_rx_ready),
        .ua_tx_data(ua_tx_data), .ua_tx_valid(ua_tx_valid), .ua_tx_ready(ua_tx_ready),
        .rotary_event(rotary_event), .rotary_left(rotary_left), .stop(stop),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .tone_period(tone_period), .tone_enable(tone_enable),
        .queue_count(queue_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] rom_model(input logic [7:0] a);
        return (a == 8'h20) ? 24'd0 : ({16'h0, a} + 24'd100);
    endfunction

    always @(posedge clk) rom_data <= rom_model(rom_addr);

    // TX ready driver: 0 = always ready, 1 = stalled, 2 = random
    int tx_mode = 0;
    always begin
        @(posedge clk);
        #1;
        case (tx_mode)
            0:       ua_tx_ready = 1'b1;
            1:       ua_tx_ready = 1'b0;
            default: ua_tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Reference model
    typedef struct {
        logic [23:0] period;
        int          len;
    } note_t;

    int          model_len = LEN_DEF;
    logic [7:0]  echo_q[$];
    note_t       note_q[$];

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event did not match expectation (t=%0t)", name, $time);
    endtask

    function automatic void model_push(input logic [7:0] b);
        note_t n;
        echo_q.push_back(b);
        if (rom_model(b) != 24'd0) begin
            n.period = rom_model(b);
            n.len    = model_len;
            note_q.push_back(n);
        end
    endfunction

    // Monitor: echo handshakes and tone windows against the scoreboard
    logic        prev_en = 1'b0;
    int          win_len = 0;
    logic [23:0] win_period = '0;
    bit          have_fall = 0;
    int          fall_cyc = 0;
    bit          skip_window = 0;
    bit          gap_check = 0;
    bit          hold_valid = 0;
    logic [7:0]  hold_data = '0;
    int          gap_q[$];
    int          rise_q[$];
    int          hs_q[$];

    always @(negedge clk) begin
        logic [7:0] eb;
        note_t      n;
        if (ua_tx_valid) begin
            if (hold_valid) check("echo_stable", 32'(ua_tx_data), 32'(hold_data));
            hold_valid = 1;
            hold_data  = ua_tx_data;
            if (ua_tx_ready) begin
                hold_valid = 0;
                hs_q.push_back(cyc + 1);
                if (echo_q.size() == 0) begin
                    fail_now("echo_unexpected");
                end else begin
                    eb = echo_q.pop_front();
                    check("echo_byte", 32'(ua_tx_data), 32'(eb));
                end
            end
        end else begin
            hold_valid = 0;
        end

        if (tone_enable) begin
            if (!prev_en) begin
                win_len    = 1;
                win_period = tone_period;
                rise_q.push_back(cyc);
                if (gap_check && have_fall) gap_q.push_back(cyc - fall_cyc);
            end else begin
                win_len++;
                check("period_hold", 32'(tone_period), 32'(win_period));
            end
        end else if (prev_en) begin
            have_fall = 1;
            fall_cyc  = cyc;
            if (skip_window) begin
                skip_window = 0;
            end else if (note_q.size() == 0) begin
                fail_now("note_unexpected");
            end else begin
                n = note_q.pop_front();
                check("note_period", 32'(win_period), 32'(n.period));
                check("note_len", 32'(win_len), 32'(n.len));
            end
        end
        prev_en = tone_enable;
    end

    // Stimulus tasks; all start and end at posedge+1
    task automatic push_byte(input logic [7:0] b, output int acc_cyc, output int cnt_at_acc);
        bit acc = 0;
        acc_cyc    = -1;
        cnt_at_acc = -1;
        ua_rx_data  = b;
        ua_rx_valid = 1'b1;
        for (int i = 0; i < 400 && !acc; i++) begin
            @(negedge clk);
            if (ua_rx_ready) begin
                acc        = 1;
                acc_cyc    = cyc + 1;
                cnt_at_acc = int'(queue_count);
                model_push(b);
            end
            @(posedge clk);
            #1;
        end
        ua_rx_valid = 1'b0;
        if (!acc) fail_now("push_timeout");
    endtask

    task automatic push(input logic [7:0] b);
        int a;
        int c;
        push_byte(b, a, c);
    endtask

    task automatic rot(input bit left);
        rotary_left  = left;
        rotary_event = 1'b1;
        @(posedge clk);
        #1;
        rotary_event = 1'b0;
        if (left) model_len = (model_len - STEP < LMIN) ? LMIN : model_len - STEP;
        else      model_len = (model_len + STEP > LMAX) ? LMAX : model_len + STEP;
    endtask

    task automatic wait_drain(input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!busy && queue_count == 0 && !ua_tx_valid && !tone_enable &&
                note_q.size() == 0 && echo_q.size() == 0) done = 1;
        end
        @(posedge clk);
        #1;
        if (!done) fail_now("drain_timeout");
    endtask

    task automatic wait_rise(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (tone_enable) seen = 1;
        end
        @(posedge clk);
        #1;
        if (!seen) fail_now("rise_timeout");
    endtask

    initial begin
        int acc_c;
        int cnt_c;
        int hi_cnt;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_ready", 32'(ua_rx_ready), 32'd0);
        check("rst_tone_enable", 32'(tone_enable), 32'd0);
        check("rst_tone_period", 32'(tone_period), 32'd0);
        check("rst_tx_valid", 32'(ua_tx_valid), 32'd0);
        check("rst_tx_data", 32'(ua_tx_data), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(queue_count), 32'd0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        @(negedge clk);
        check("post_rst_rx_ready", 32'(ua_rx_ready), 32'd1);
        @(posedge clk);
        #1;

        // Single note: 'A' -> period 165, 10 cycles, starts 3 edges after push
        rise_q.delete();
        push_byte(8'h41, acc_c, cnt_c);
        wait_drain(200);
        if (rise_q.size() > 0) check("single_start_delay", 32'(rise_q[0] - acc_c), 32'd3);
        else fail_now("single_no_tone");

        // Back-to-back notes separated by exactly 3 low cycles
        gap_q.delete();
        gap_check = 1;
        push(8'h41);
        push(8'h42);
        push(8'h43);
        wait_drain(300);
        gap_check = 0;
        check("b2b_windows", 32'(gap_q.size()), 32'd3);
        if (gap_q.size() >= 3) begin
            check("b2b_gap1", 32'(gap_q[1]), 32'd3);
            check("b2b_gap2", 32'(gap_q[2]), 32'd3);
        end

        // Full queue during a note; 5th byte only after the next pop
        push(8'h44);
        wait_rise(50);
        push(8'h45);
        push(8'h46);
        push(8'h47);
        push(8'h48);
        @(negedge clk);
        check("full_count", 32'(queue_count), 32'd4);
        check("full_ready", 32'(ua_rx_ready), 32'd0);
        @(posedge clk);
        #1;
        push_byte(8'h49, acc_c, cnt_c);
        check("fifth_after_pop", 32'(cnt_c), 32'd3);
        wait_drain(400);

        // Rest with TX stalled; 'A' starts 3 edges after the rest echo handshake
        tx_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        rise_q.delete();
        hs_q.delete();
        push(8'h20);
        push(8'h41);
        hi_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tone_enable) hi_cnt++;
        end
        check("rest_silent", 32'(hi_cnt), 32'd0);
        check("stall_busy", 32'(busy), 32'd0);
        check("stall_count", 32'(queue_count), 32'd1);
        @(posedge clk);
        #1;
        tx_mode = 0;
        wait_drain(300);
        if (rise_q.size() > 0 && hs_q.size() > 0)
            check("stall_start_delay", 32'(rise_q[0] - hs_q[0]), 32'd3);
        else fail_now("stall_no_tone");

        // Rotary saturation
        repeat (6) rot(1'b0);
        push(8'h42);
        wait_drain(300);
        repeat (12) rot(1'b1);
        push(8'h43);
        wait_drain(300);
        push(8'h44);
        wait_rise(50);
        rot(1'b0);
        wait_drain(300);
        push(8'h45);
        wait_drain(300);

        // Stop during PLAY with 3 bytes queued
        repeat (3) rot(1'b0);
        push(8'h41);
        wait_rise(50);
        push(8'h42);
        push(8'h43);
        push(8'h44);
        @(negedge clk);
        check("stop_pre_count", 32'(queue_count), 32'd3);
        @(posedge clk);
        #1;
        skip_window = 1;
        stop        = 1'b1;
        ua_rx_data  = 8'h5a;
        ua_rx_valid = 1'b1;
        @(negedge clk);
        check("stop_rx_ready", 32'(ua_rx_ready), 32'd0);
        @(posedge clk);
        #1;
        stop        = 1'b0;
        ua_rx_valid = 1'b0;
        note_q.delete();
        echo_q.delete();
        check("stop_tone_enable", 32'(tone_enable), 32'd0);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_count", 32'(queue_count), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("stop_rejected_byte", 32'(busy), 32'd0);
        push(8'h45);
        wait_drain(300);

        // Randomized traffic with random TX stalls and rotary steps between bursts
        tx_mode = 2;
        for (int it = 0; it < 8; it++) begin
            int nrot;
            int npush;
            nrot = $urandom_range(0, 4);
            for (int r = 0; r < nrot; r++) rot(1'($urandom_range(0, 1)));
            npush = $urandom_range(1, 5);
            for (int p = 0; p < npush; p++) begin
                logic [7:0] b;
                if ($urandom_range(0, 5) == 0) b = 8'h20;
                else b = 8'(8'h41 + $urandom_range(0, 25));
                push(b);
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
            wait_drain(2000);
        end
        tx_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset mid-note, then default duration again
        push(8'h41);
        wait_rise(50);
        skip_window = 1;
        rst_b = 1'b0;
        #1;
        check("arst_tone_enable", 32'(tone_enable), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_rx_ready", 32'(ua_rx_ready), 32'd0);
        check("arst_tx_valid", 32'(ua_tx_valid), 32'd0);
        note_q.delete();
        echo_q.delete();
        model_len = LEN_DEF;
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        push(8'h42);
        wait_drain(300);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/piano_scheduler.md
Name: piano_scheduler

Overview:
- Sequencing controller between the UART receive path and the square-wave tone generator that feeds the AC97 controller.
- Buffers ASCII note bytes from UART RX in a small queue and looks each byte up in an external note-period ROM.
- Plays each note for a programmable duration, set by the rotary wheel, and echoes each started note on UART TX.
- A stop pulse (compass button) aborts playback and flushes the queue.

Parameters:
- CLOCK_FREQ, 33_000_000: system clock frequency in Hz.
- NOTE_LEN_DEFAULT, CLOCK_FREQ/5: note duration in cycles after reset.
- NOTE_LEN_STEP, CLOCK_FREQ/50: duration change per rotary event.
- NOTE_LEN_MIN, CLOCK_FREQ/50: lower saturation bound for duration.
- NOTE_LEN_MAX, CLOCK_FREQ: upper saturation bound for duration.
- QUEUE_DEPTH, 4: note queue entries; must be a power of 2 and at least 2.

Ports:
- clk  input  1  system clock (33 MHz domain).
- rst_b  input  1  asynchronous active-low reset.
- ua_rx_data  input  8  received byte.
- ua_rx_valid  input  1  received byte valid.
- ua_rx_ready  output  1  queue accepts a byte this cycle.
- ua_tx_data  output  8  echo byte.
- ua_tx_valid  output  1  echo byte valid.
- ua_tx_ready  input  1  UART TX accepts the byte.
- rotary_event  input  1  one-cycle rotary step pulse.
- rotary_left  input  1  direction of the step; 1 = decrease duration.
- stop  input  1  one-cycle abort/flush pulse.
- rom_addr  output  8  note ROM address (registered).
- rom_data  input  24  tone period; valid 1 cycle after rom_addr; 0 = rest.
- tone_period  output  24  period sent to the tone generator.
- tone_enable  output  1  tone generator enable.
- queue_count  output  log2(QUEUE_DEPTH)+1  entries currently queued.
- busy  output  1  FSM is not in IDLE.

Behaviour:
- Reset values: ua_rx_ready 0 while rst_b low, then !full. All other outputs are 0. note_len = NOTE_LEN_DEFAULT. Queue is empty and FSM is in IDLE.
- Queue push: occurs when ua_rx_valid & ua_rx_ready.
  - ua_rx_ready = !full & !stop. It is combinational and does not account for a same-cycle pop.
  - A push and a pop in the same cycle are both honoured; count is unchanged.
  - Pointers wrap modulo QUEUE_DEPTH.
- IDLE: moves to FETCH when queue is not empty and ua_tx_valid = 0. On that edge it pops the head entry and registers it into rom_addr and an internal echo byte.
- FETCH: lasts 1 cycle (the ROM read), then moves to LOAD.
- LOAD: on the edge leaving LOAD:
  - tone_period <= rom_data; tone_enable <= (rom_data != 0).
  - Counter <= note_len - 1.
  - ua_tx_data <= echo byte; ua_tx_valid <= 1.
  - State moves to PLAY.
- PLAY: counter decrements each cycle. When the counter is 0: tone_enable <= 0, tone_period holds, state moves to IDLE.
  - PLAY lasts exactly note_len cycles, so tone_enable is high for exactly note_len cycles on non-rest notes.
  - Back-to-back notes have exactly 3 low cycles between them (IDLE, FETCH, LOAD) when TX is not stalled.
- Echo: ua_tx_valid clears on the edge where ua_tx_valid & ua_tx_ready. ua_tx_data is stable while valid. A stalled TX delays only the start of the next note, never the current one.
- Duration control:
  - rotary_event with !rotary_left: note_len = min(note_len + STEP, MAX).
  - rotary_event with rotary_left: note_len = max(note_len - STEP, MIN).
  - Saturating; intermediate arithmetic is 32 bits.
  - A change during PLAY affects only later notes.
- stop, any state: next edge flushes the queue (count 0), clears tone_enable, and forces IDLE.
  - A byte presented the same cycle is not accepted (ready is low).
  - A pending echo (ua_tx_valid) is kept until accepted.
  - note_len is unaffected.
- Reset mid-note returns all state to reset values immediately (asynchronous).
- busy = (state != IDLE).

Test Plan:
- Bench parameters: NOTE_LEN_DEFAULT=10, STEP=2, MIN=2, MAX=20, DEPTH=4. ROM returns {16'h0, addr} + 24'd100 except addr 8'h20 → 0. ua_tx_ready tied 1 unless stated.
- Single note: push 8'h41 → ua_tx_data=8'h41 echoed once; tone_period=24'd165; tone_enable high exactly 10 cycles, starting 3 cycles after the push.
- Back-to-back: push 'A','B','C' consecutively → three 10-cycle enable windows separated by exactly 3 low cycles. Echoes arrive in order 41, 42, 43.
- Full queue: during a note, push 5 bytes → ua_rx_ready low with queue_count=4. The 5th byte is accepted only after the next pop.
- Rest and TX stall: push 8'h20 then 'A' with ua_tx_ready=0 for 30 cycles → enable stays 0 during the rest. 'A' starts only 3 cycles after the first echo handshake.
- Rotary saturation:
  - 6 right events → note_len=20.
  - 12 left events → note_len=2.
  - One right event issued mid-note leaves that note's length unchanged.
- Stop: stop during PLAY with 3 bytes queued → next cycle tone_enable=0, busy=0, queue_count=0. A byte offered in the stop cycle is rejected.
